// File: rtl/output_argmax.sv
// Argmax consumer for the output layer: captures the scores on a rising ready
// edge, then scans them one per clock and reports the winning class and its score.
module output_argmax #(
    parameter int unsigned BITS            = 16,
    parameter int unsigned FRACTIONAL_BITS = 11,
    parameter int unsigned OUT_SIZE        = 10,
    localparam int unsigned IDX_W          = $clog2(OUT_SIZE)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ready,
    input  logic signed [BITS-1:0] in [0:OUT_SIZE-1],
    output logic [IDX_W-1:0]       class_idx,
    output logic signed [BITS-1:0] max_score,
    output logic                   valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_SIZE - 1);

    // Parameter sanity: the scan needs at least two entries, and the fraction must fit the word.
    if (OUT_SIZE < 2 || FRACTIONAL_BITS >= BITS) begin : g_param_check
        $error("output_argmax: OUT_SIZE must be >= 2 and FRACTIONAL_BITS < BITS");
    end

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                 state, state_d;
    logic                   ready_q;
    logic                   rise;
    logic signed [BITS-1:0] snap   [0:OUT_SIZE-1];
    logic signed [BITS-1:0] snap_d [0:OUT_SIZE-1];
    logic signed [BITS-1:0] best, best_d;
    logic [IDX_W-1:0]       best_idx, best_idx_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [IDX_W-1:0]       class_idx_d;
    logic signed [BITS-1:0] max_score_d;
    logic                   valid_d, busy_d, overrun_d;
    logic signed [BITS-1:0] cand;
    logic                   take;

    assign rise = ready & ~ready_q;

    // Next-state and datapath: capture in IDLE, one strict signed compare per SCAN cycle.
    always_comb begin
        state_d     = state;
        snap_d      = snap;
        best_d      = best;
        best_idx_d  = best_idx;
        idx_d       = idx;
        class_idx_d = class_idx;
        max_score_d = max_score;
        valid_d     = valid;
        busy_d      = busy;
        overrun_d   = 1'b0;
        cand        = snap[idx];
        take        = cand > best;

        case (state)
            IDLE: begin
                if (rise) begin
                    snap_d     = in;
                    best_d     = in[0];
                    best_idx_d = '0;
                    idx_d      = IDX_W'(1);
                    valid_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // A fresh start during a scan is dropped and flagged.
                overrun_d = rise;
                if (take) begin
                    best_d     = cand;
                    best_idx_d = idx;
                end
                if (idx == LAST) begin
                    class_idx_d = take ? idx : best_idx;
                    max_score_d = take ? cand : best;
                    valid_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            best      <= '0;
            best_idx  <= '0;
            idx       <= '0;
            class_idx <= '0;
            max_score <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < int'(OUT_SIZE); i++) begin
                snap[i] <= '0;
            end
        end else begin
            state     <= state_d;
            ready_q   <= ready;
            snap      <= snap_d;
            best      <= best_d;
            best_idx  <= best_idx_d;
            idx       <= idx_d;
            class_idx <= class_idx_d;
            max_score <= max_score_d;
            valid     <= valid_d;
            busy      <= busy_d;
            overrun   <= overrun_d;
        end
    end

endmodule
